// File: rtl/mem_access_ctrl_if.sv
// Datapath-side request/result signals and RAM-side MOV/MOC bus of the load/store sequencer.
// slave is the sequencer's view; master is the view of the datapath and RAM driving it.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              Start;
  logic [5:0]        Op3;
  logic [ADDR_W-1:0] Addr;
  logic [31:0]       StoreData;
  logic [31:0]       StoreData2;
  logic [31:0]       LoadData;
  logic [31:0]       LoadData2;
  logic              Done;
  logic              Busy;
  logic              AlignTrap;
  logic              IllegalOp;
  logic              MemError;
  logic              MemMOV;
  logic              MemReadWrite;
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemDataIn;
  logic [5:0]        MemOP;
  logic [31:0]       MemDataOut;
  logic              MemMOC;

  modport master (
    output Start, Op3, Addr, StoreData, StoreData2, MemDataOut, MemMOC,
    input  LoadData, LoadData2, Done, Busy, AlignTrap, IllegalOp, MemError,
    input  MemMOV, MemReadWrite, MemAddress, MemDataIn, MemOP
  );

  modport slave (
    input  Start, Op3, Addr, StoreData, StoreData2, MemDataOut, MemMOC,
    output LoadData, LoadData2, Done, Busy, AlignTrap, IllegalOp, MemError,
    output MemMOV, MemReadWrite, MemAddress, MemDataIn, MemOP
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// SPARC V8 load/store sequencer for a byte-addressed RAM with a MOV/MOC handshake.
// Adds LDD/STD splitting, LDSB/LDSH sign extension, alignment/illegal-op traps and MOC timeout.
module mem_access_ctrl #(
  parameter int MOC_TIMEOUT = 15,
  parameter int ADDR_W      = 9
) (
  input  logic              Clk,
  input  logic              Clr,
  mem_access_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] FIN     = 3'd4;

  localparam int NUM_OPS = 10;
  localparam int CNT_W   = $clog2(MOC_TIMEOUT + 1);

  // Entry i sits at the low end: LD, LDUB, LDUH, LDD, ST, STB, STH, STD, LDSB, LDSH.
  localparam logic [NUM_OPS*6-1:0] OP3_TAB = {
    6'b001010, 6'b001001, 6'b000111, 6'b000110, 6'b000101,
    6'b000100, 6'b000011, 6'b000010, 6'b000001, 6'b000000};
  localparam logic [NUM_OPS*6-1:0] MOP_TAB = {
    6'b000010, 6'b000001, 6'b000100, 6'b000110, 6'b000101,
    6'b000100, 6'b001000, 6'b000010, 6'b000001, 6'b001000};
  localparam logic [NUM_OPS*2-1:0] SIZE_TAB = {
    2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2};
  localparam logic [NUM_OPS-1:0] LOAD_TAB = 10'b11_0000_1111;
  localparam logic [NUM_OPS-1:0] SIGN_TAB = 10'b11_0000_0000;

  logic [NUM_OPS-1:0] hit;
  logic               dec_legal;
  logic [5:0]         dec_mop;
  logic [1:0]         dec_size;
  logic               dec_load;
  logic               dec_sign;
  logic               dec_misalign;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_hit
      assign hit[gi] = (bus.Op3 == OP3_TAB[gi*6 +: 6]);
    end
  endgenerate

  always_comb begin
    dec_legal = |hit;
    dec_mop   = '0;
    dec_size  = '0;
    dec_load  = 1'b0;
    dec_sign  = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (hit[i]) begin
        dec_mop  = MOP_TAB[i*6 +: 6];
        dec_size = SIZE_TAB[i*2 +: 2];
        dec_load = LOAD_TAB[i];
        dec_sign = SIGN_TAB[i];
      end
    end
    case (dec_size)
      2'd1:    dec_misalign = bus.Addr[0];
      2'd2:    dec_misalign = |bus.Addr[1:0];
      2'd3:    dec_misalign = |bus.Addr[2:0];
      default: dec_misalign = 1'b0;
    endcase
  end

  logic [2:0]        state_reg,  state_next;
  logic              load_reg,   load_next;
  logic [1:0]        size_reg,   size_next;
  logic              sign_reg,   sign_next;
  logic              second_reg, second_next;
  logic [31:0]       sd2_reg,    sd2_next;
  logic [CNT_W-1:0]  cnt_reg,    cnt_next;
  logic              mov_reg,    mov_next;
  logic              rw_reg,     rw_next;
  logic [ADDR_W-1:0] maddr_reg,  maddr_next;
  logic [31:0]       mdin_reg,   mdin_next;
  logic [5:0]        mop_reg,    mop_next;
  logic [31:0]       ld_reg,     ld_next;
  logic [31:0]       ld2_reg,    ld2_next;
  logic              done_reg,   done_next;
  logic              busy_reg,   busy_next;
  logic              align_reg,  align_next;
  logic              ill_reg,    ill_next;
  logic              merr_reg,   merr_next;
  logic [31:0]       ld_fmt;

  // The RAM already zero-extends sub-word reads; only signed loads need widening here.
  always_comb begin
    ld_fmt = bus.MemDataOut;
    if (sign_reg && size_reg == 2'd0)
      ld_fmt = {{24{bus.MemDataOut[7]}}, bus.MemDataOut[7:0]};
    else if (sign_reg && size_reg == 2'd1)
      ld_fmt = {{16{bus.MemDataOut[15]}}, bus.MemDataOut[15:0]};
  end

  always_comb begin
    state_next  = state_reg;
    load_next   = load_reg;
    size_next   = size_reg;
    sign_next   = sign_reg;
    second_next = second_reg;
    sd2_next    = sd2_reg;
    cnt_next    = cnt_reg;
    mov_next    = mov_reg;
    rw_next     = rw_reg;
    maddr_next  = maddr_reg;
    mdin_next   = mdin_reg;
    mop_next    = mop_reg;
    ld_next     = ld_reg;
    ld2_next    = ld2_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    align_next  = 1'b0;
    ill_next    = 1'b0;
    merr_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.Start) begin
          busy_next   = 1'b1;
          load_next   = dec_load;
          size_next   = dec_size;
          sign_next   = dec_sign;
          second_next = 1'b0;
          if (!dec_legal) begin
            ill_next   = 1'b1;
            done_next  = 1'b1;
            state_next = FIN;
          end else if (dec_misalign) begin
            align_next = 1'b1;
            done_next  = 1'b1;
            state_next = FIN;
          end else begin
            state_next = ISSUE;
            mov_next   = 1'b1;
            rw_next    = dec_load;
            maddr_next = bus.Addr;
            mdin_next  = bus.StoreData;
            mop_next   = dec_mop;
            sd2_next   = bus.StoreData2;
          end
        end
      end
      // MOC may still be high from the previous access, so it is not looked at here.
      ISSUE: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        if (bus.MemMOC) begin
          mov_next   = 1'b0;
          state_next = RELEASE;
          if (load_reg) begin
            if (second_reg) ld2_next = bus.MemDataOut;
            else            ld_next  = ld_fmt;
          end
        end else if (cnt_reg == CNT_W'(MOC_TIMEOUT - 1)) begin
          mov_next   = 1'b0;
          merr_next  = 1'b1;
          done_next  = 1'b1;
          state_next = FIN;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (size_reg == 2'd3 && !second_reg) begin
          second_next = 1'b1;
          state_next  = ISSUE;
          mov_next    = 1'b1;
          maddr_next  = maddr_reg + ADDR_W'(4);
          mdin_next   = sd2_reg;
        end else begin
          done_next  = 1'b1;
          state_next = FIN;
        end
      end
      FIN: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_reg  <= IDLE;
      load_reg   <= 1'b0;
      size_reg   <= '0;
      sign_reg   <= 1'b0;
      second_reg <= 1'b0;
      sd2_reg    <= '0;
      cnt_reg    <= '0;
      mov_reg    <= 1'b0;
      rw_reg     <= 1'b0;
      maddr_reg  <= '0;
      mdin_reg   <= '0;
      mop_reg    <= '0;
      ld_reg     <= '0;
      ld2_reg    <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      align_reg  <= 1'b0;
      ill_reg    <= 1'b0;
      merr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      load_reg   <= load_next;
      size_reg   <= size_next;
      sign_reg   <= sign_next;
      second_reg <= second_next;
      sd2_reg    <= sd2_next;
      cnt_reg    <= cnt_next;
      mov_reg    <= mov_next;
      rw_reg     <= rw_next;
      maddr_reg  <= maddr_next;
      mdin_reg   <= mdin_next;
      mop_reg    <= mop_next;
      ld_reg     <= ld_next;
      ld2_reg    <= ld2_next;
      done_reg   <= done_next;
      busy_reg   <= busy_next;
      align_reg  <= align_next;
      ill_reg    <= ill_next;
      merr_reg   <= merr_next;
    end
  end

  assign bus.LoadData     = ld_reg;
  assign bus.LoadData2    = ld2_reg;
  assign bus.Done         = done_reg;
  assign bus.Busy         = busy_reg;
  assign bus.AlignTrap    = align_reg;
  assign bus.IllegalOp    = ill_reg;
  assign bus.MemError     = merr_reg;
  assign bus.MemMOV       = mov_reg;
  assign bus.MemReadWrite = rw_reg;
  assign bus.MemAddress   = maddr_reg;
  assign bus.MemDataIn    = mdin_reg;
  assign bus.MemOP        = mop_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural big-endian 512x8 RAM answering MOV on its rising edge.
module tb_mem_access_ctrl;

  logic Clk;
  logic Clr;
  int   vectors;
  int   miscompares;

  mem_access_ctrl_if #(.ADDR_W(9)) bus ();

  mem_access_ctrl #(.MOC_TIMEOUT(15), .ADDR_W(9)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RAM model
  logic [7:0] mem [512];
  logic       mov_prev;
  logic       moc_kill;
  logic [8:0] ra0, ra1, ra2, ra3;

  always @(posedge Clk) begin
    if (!Clr) begin
      mov_prev       <= 1'b0;
      bus.MemMOC     <= 1'b0;
      bus.MemDataOut <= '0;
    end else begin
      mov_prev <= bus.MemMOV;
      if (!bus.MemMOV) begin
        bus.MemMOC <= 1'b0;
      end else if (!mov_prev && !moc_kill) begin
        bus.MemMOC <= 1'b1;
        ra0 = bus.MemAddress;
        ra1 = ra0 + 9'd1;
        ra2 = ra0 + 9'd2;
        ra3 = ra0 + 9'd3;
        case (bus.MemOP)
          6'b001000: bus.MemDataOut <= {mem[ra0], mem[ra1], mem[ra2], mem[ra3]};
          6'b000001: bus.MemDataOut <= {24'h0, mem[ra0]};
          6'b000010: bus.MemDataOut <= {16'h0, mem[ra0], mem[ra1]};
          6'b000100: begin
            mem[ra0] <= bus.MemDataIn[31:24];
            mem[ra1] <= bus.MemDataIn[23:16];
            mem[ra2] <= bus.MemDataIn[15:8];
            mem[ra3] <= bus.MemDataIn[7:0];
          end
          6'b000101: mem[ra0] <= bus.MemDataIn[7:0];
          6'b000110: begin
            mem[ra0] <= bus.MemDataIn[15:8];
            mem[ra1] <= bus.MemDataIn[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Runs one request; returns Done latency (edges after accept), MOV statistics and flags at Done.
  task automatic do_op(input logic [5:0] op3, input logic [8:0] addr,
                       input logic [31:0] sd, input logic [31:0] sd2,
                       output int lat, output int movs, output int movcyc,
                       output logic [8:0] a0, output logic [8:0] a1,
                       output logic [5:0] op0, output logic rw0,
                       output logic [2:0] flg, output logic bsy);
    logic prev;
    lat = -1; movs = 0; movcyc = 0; a0 = '0; a1 = '0; op0 = '0; rw0 = 1'b0;
    flg = '0; bsy = 1'b0; prev = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.Op3 = op3; bus.Addr = addr;
    bus.StoreData = sd; bus.StoreData2 = sd2;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 40 && lat < 0; c++) begin
      if (c > 0) begin @(posedge Clk); #1; end
      if (bus.MemMOV) begin
        movcyc++;
        if (!prev) begin
          if (movs == 0) begin a0 = bus.MemAddress; op0 = bus.MemOP; rw0 = bus.MemReadWrite; end
          else a1 = bus.MemAddress;
          movs++;
        end
      end
      prev = bus.MemMOV;
      if (bus.Done) begin
        lat = c;
        flg = {bus.AlignTrap, bus.IllegalOp, bus.MemError};
        bsy = bus.Busy;
      end
    end
    @(posedge Clk); #1;
    $display("op3=%b addr=%0d lat=%0d movs=%0d a0=%0d a1=%0d flags=%b LoadData=%h LoadData2=%h",
             op3, addr, lat, movs, a0, a1, flg, bus.LoadData, bus.LoadData2);
  endtask

  task automatic test_reset();
    logic [117:0] outs;
    repeat (3) @(posedge Clk);
    #1;
    outs = {bus.Done, bus.Busy, bus.AlignTrap, bus.IllegalOp, bus.MemError, bus.MemMOV,
            bus.MemReadWrite, bus.MemAddress, bus.MemDataIn, bus.MemOP, bus.LoadData, bus.LoadData2};
    vectors++;
    if (outs !== '0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    Clr = 1'b1;
    $display("reset released");
  endtask

  task automatic test_word();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    do_op(6'b000100, 9'd0, 32'hAE910F2B, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL st_latency: got %0d expected 3", lat); end
    vectors++; if (mc !== 2 || movs !== 1) begin miscompares++; $display("FAIL st_mov: got cyc=%0d pulses=%0d expected 2/1", mc, movs); end
    vectors++; if (op0 !== 6'b000100 || rw0 !== 1'b0) begin miscompares++; $display("FAIL st_op: got %b rw=%b expected 000100 rw=0", op0, rw0); end
    vectors++; if ({mem[0], mem[1], mem[2], mem[3]} !== 32'hAE910F2B) begin miscompares++; $display("FAIL st_mem: got %h expected AE910F2B", {mem[0], mem[1], mem[2], mem[3]}); end
    do_op(6'b000000, 9'd0, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL ld_latency: got %0d expected 3", lat); end
    vectors++; if (op0 !== 6'b001000 || rw0 !== 1'b1) begin miscompares++; $display("FAIL ld_op: got %b rw=%b expected 001000 rw=1", op0, rw0); end
    vectors++; if (bus.LoadData !== 32'hAE910F2B) begin miscompares++; $display("FAIL ld_data: got %h expected AE910F2B", bus.LoadData); end
  endtask

  task automatic test_sign_ext();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    do_op(6'b000101, 9'd6, 32'h123456F0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (mem[6] !== 8'hF0 || op0 !== 6'b000101) begin miscompares++; $display("FAIL stb: got mem=%h op=%b expected F0/000101", mem[6], op0); end
    do_op(6'b001001, 9'd6, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'hFFFFFFF0 || op0 !== 6'b000001) begin miscompares++; $display("FAIL ldsb_neg: got %h op=%b expected FFFFFFF0/000001", bus.LoadData, op0); end
    do_op(6'b000001, 9'd6, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'h000000F0) begin miscompares++; $display("FAIL ldub: got %h expected 000000F0", bus.LoadData); end
    do_op(6'b001010, 9'd6, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'hFFFFF000 || op0 !== 6'b000010) begin miscompares++; $display("FAIL ldsh_neg: got %h op=%b expected FFFFF000/000010", bus.LoadData, op0); end
    do_op(6'b001001, 9'd1, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'hFFFFFF91) begin miscompares++; $display("FAIL ldsb_91: got %h expected FFFFFF91", bus.LoadData); end
    do_op(6'b000010, 9'd2, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'h00000F2B) begin miscompares++; $display("FAIL lduh: got %h expected 00000F2B", bus.LoadData); end
    do_op(6'b000110, 9'd30, 32'hFFFF7ABC, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    do_op(6'b001010, 9'd30, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (bus.LoadData !== 32'h00007ABC) begin miscompares++; $display("FAIL sth_ldsh_pos: got %h expected 00007ABC", bus.LoadData); end
    vectors++; if (bus.LoadData2 !== 32'h0) begin miscompares++; $display("FAIL ld2_untouched: got %h expected 0", bus.LoadData2); end
  endtask

  task automatic test_dword();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    do_op(6'b000111, 9'd8, 32'h11223344, 32'h55667788, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL std_latency: got %0d expected 6", lat); end
    vectors++; if (movs !== 2 || mc !== 4 || a0 !== 9'd8 || a1 !== 9'd12) begin miscompares++; $display("FAIL std_addr: got pulses=%0d cyc=%0d a=%0d,%0d expected 2/4/8,12", movs, mc, a0, a1); end
    vectors++; if (bus.LoadData !== 32'h00007ABC) begin miscompares++; $display("FAIL std_keeps_load: got %h expected 00007ABC", bus.LoadData); end
    do_op(6'b000011, 9'd8, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (lat !== 6 || a1 !== 9'd12) begin miscompares++; $display("FAIL ldd_timing: got lat=%0d a1=%0d expected 6/12", lat, a1); end
    vectors++; if (bus.LoadData !== 32'h11223344 || bus.LoadData2 !== 32'h55667788) begin miscompares++; $display("FAIL ldd_data: got %h %h expected 11223344 55667788", bus.LoadData, bus.LoadData2); end
    do_op(6'b000111, 9'd504, 32'hA1B2C3D4, 32'h0F1E2D3C, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    do_op(6'b000011, 9'd504, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (a1 !== 9'd508 || bus.LoadData !== 32'hA1B2C3D4 || bus.LoadData2 !== 32'h0F1E2D3C) begin miscompares++; $display("FAIL ldd_top: got a1=%0d %h %h expected 508 A1B2C3D4 0F1E2D3C", a1, bus.LoadData, bus.LoadData2); end
  endtask

  task automatic test_traps();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    logic [5:0] ops [5];
    logic [8:0] adrs [5];
    logic [2:0] exp [5];
    ops[0] = 6'b000000; adrs[0] = 9'd2; exp[0] = 3'b100;
    ops[1] = 6'b000011; adrs[1] = 9'd4; exp[1] = 3'b100;
    ops[2] = 6'b000010; adrs[2] = 9'd5; exp[2] = 3'b100;
    ops[3] = 6'b001111; adrs[3] = 9'd0; exp[3] = 3'b010;
    ops[4] = 6'b001111; adrs[4] = 9'd1; exp[4] = 3'b010;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], adrs[i], 32'hDEADBEEF, 32'hDEADBEEF, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
      vectors++;
      if (lat !== 0 || flg !== exp[i] || movs !== 0 || bsy !== 1'b1) begin
        miscompares++;
        $display("FAIL trap_%0d: got lat=%0d flags=%b movs=%0d busy=%b expected 0/%b/0/1", i, lat, flg, movs, bsy, exp[i]);
      end
    end
    vectors++; if (bus.LoadData !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL trap_keeps_load: got %h expected A1B2C3D4", bus.LoadData); end
  endtask

  task automatic test_timeout();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    moc_kill = 1'b1;
    do_op(6'b000000, 9'd0, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    moc_kill = 1'b0;
    vectors++; if (lat !== 16 || flg !== 3'b001) begin miscompares++; $display("FAIL timeout: got lat=%0d flags=%b expected 16/001", lat, flg); end
    vectors++; if (mc !== 16 || bus.MemMOV !== 1'b0) begin miscompares++; $display("FAIL timeout_mov: got cyc=%0d mov=%b expected 16/0", mc, bus.MemMOV); end
    vectors++; if (bus.LoadData !== 32'hA1B2C3D4) begin miscompares++; $display("FAIL timeout_keeps_load: got %h expected A1B2C3D4", bus.LoadData); end
  endtask

  task automatic test_back_to_back();
    int dones, movs, lat; logic prev;
    dones = 0; movs = 0; lat = -1; prev = 1'b0;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.Op3 = 6'b000000; bus.Addr = 9'd8;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin @(posedge Clk); #1; end
      if (c == 1) begin bus.Start = 1'b1; bus.Op3 = 6'b000100; bus.Addr = 9'd40; bus.StoreData = 32'hDEADBEEF; end
      if (c == 4) bus.Start = 1'b0;
      if (bus.Done) begin dones++; lat = c; end
      if (bus.MemMOV && !prev) movs++;
      prev = bus.MemMOV;
    end
    $display("busy-ignore: dones=%0d lat=%0d movs=%0d LoadData=%h", dones, lat, movs, bus.LoadData);
    vectors++; if (dones !== 1 || lat !== 3 || movs !== 1) begin miscompares++; $display("FAIL busy_ignore: got dones=%0d lat=%0d movs=%0d expected 1/3/1", dones, lat, movs); end
    vectors++; if ({mem[40], mem[41], mem[42], mem[43]} !== 32'h0 || bus.LoadData !== 32'h11223344) begin miscompares++; $display("FAIL busy_ignore_data: got mem=%h ld=%h expected 0/11223344", {mem[40], mem[41], mem[42], mem[43]}, bus.LoadData); end
  endtask

  task automatic test_reset_mid();
    int lat, movs, mc; logic [8:0] a0, a1; logic [5:0] op0; logic rw0; logic [2:0] flg; logic bsy;
    logic [117:0] outs;
    int seen;
    @(posedge Clk); #1;
    bus.Start = 1'b1; bus.Op3 = 6'b000111; bus.Addr = 9'd16;
    bus.StoreData = 32'hCAFEF00D; bus.StoreData2 = 32'h0BADBEEF;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    vectors++; if (bus.MemMOV !== 1'b1) begin miscompares++; $display("FAIL mid_mov_before: got %b expected 1", bus.MemMOV); end
    #2 Clr = 1'b0;
    #1;
    outs = {bus.Done, bus.Busy, bus.AlignTrap, bus.IllegalOp, bus.MemError, bus.MemMOV,
            bus.MemReadWrite, bus.MemAddress, bus.MemDataIn, bus.MemOP, bus.LoadData, bus.LoadData2};
    vectors++; if (outs !== '0) begin miscompares++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
    @(posedge Clk); #1;
    Clr = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk); #1;
      if (bus.MemMOV || bus.Done || bus.Busy) seen++;
    end
    $display("mid-access reset: activity after release=%0d", seen);
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mid_reset_idle: got %0d active cycles expected 0", seen); end
    vectors++; if ({mem[20], mem[21], mem[22], mem[23]} !== 32'h0) begin miscompares++; $display("FAIL mid_second_word: got %h expected 0", {mem[20], mem[21], mem[22], mem[23]}); end
    do_op(6'b000000, 9'd16, 32'h0, 32'h0, lat, movs, mc, a0, a1, op0, rw0, flg, bsy);
    vectors++; if (lat !== 3 || bus.LoadData !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mid_recover: got lat=%0d %h expected 3/CAFEF00D", lat, bus.LoadData); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    moc_kill = 1'b0;
    Clr = 1'b0;
    bus.Start = 1'b0;
    bus.Op3 = '0;
    bus.Addr = '0;
    bus.StoreData = '0;
    bus.StoreData2 = '0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_word();
    test_sign_ext();
    test_dword();
    test_traps();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Load/store sequencer between the SPARC V8 datapath and the byte-addressed 512x8 RAM. It accepts one memory instruction, identified by its op3, and checks alignment. It translates op3 into the RAM's OP encoding and runs the MOV/MOC handshake. It also provides the functions the RAM does not: LDD/STD (split into two word accesses), sign extension for LDSB/LDSH, and error reporting.

Parameters:
MOC_TIMEOUT, 15, WAIT-state cycles allowed before MOC is declared missing
ADDR_W, 9, RAM byte-address width

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  asynchronous active-low reset
Start  in  1  request strobe, sampled only in IDLE
Op3  in  6  SPARC op3 of the memory instruction
Addr  in  ADDR_W  effective byte address
StoreData  in  32  store data (rd, even reg for STD)
StoreData2  in  32  STD second word (rd+1)
LoadData  out  32  load result (even reg for LDD)
LoadData2  out  32  LDD second word (rd+1)
Done  out  1  one-cycle completion pulse (also on trap/error)
Busy  out  1  high from Start accept until Done cycle inclusive
AlignTrap  out  1  mem_address_not_aligned, valid with Done
IllegalOp  out  1  unsupported op3, valid with Done
MemError  out  1  MOC timeout, valid with Done
MemMOV  out  1  RAM access strobe
MemReadWrite  out  1  1 = load, 0 = store
MemAddress  out  ADDR_W  RAM address
MemDataIn  out  32  data to RAM
MemOP  out  6  RAM op encoding
MemDataOut  in  32  data from RAM
MemMOC  in  1  RAM completion

Behaviour:
- Reset (Clr=0, async): state IDLE; all outputs 0 (including MemMOV, LoadData, LoadData2, flags). Reset in mid-access abandons the access. MemMOV drops immediately; any second LDD/STD word is not issued.
- All outputs are registered. Op3, Addr, StoreData and StoreData2 are latched when Start is accepted. Start while Busy is ignored.
- Supported op3 and RAM OP mapping:
  - LD 000000 -> 001000
  - LDUB 000001 -> 000001
  - LDUH 000010 -> 000010
  - LDD 000011 -> 001000 (x2)
  - ST 000100 -> 000100
  - STB 000101 -> 000101
  - STH 000110 -> 000110
  - STD 000111 -> 000100 (x2)
  - LDSB 001001 -> 000001
  - LDSH 001010 -> 000010
  - Any other op3: IllegalOp.
- Alignment rules: halfword requires Addr[0]=0; word requires Addr[1:0]=0; doubleword requires Addr[2:0]=0. Byte accesses are never misaligned.
- IllegalOp takes priority over AlignTrap. On either, no MemMOV is issued. Done and the flag pulse in the cycle after Start is accepted. LoadData is unchanged.
- States: IDLE, ISSUE, WAIT, RELEASE, FIN.
  - IDLE -> ISSUE on a legal, aligned Start. MemMOV=1; MemAddress, MemOP, MemReadWrite and MemDataIn are driven.
  - ISSUE -> WAIT unconditionally. MemMOV is held at 1. MemMOC is ignored in ISSUE, because it stays high from the previous access.
  - WAIT: when MemMOC=1, capture MemDataOut (loads), go to RELEASE, MemMOV=0.
  - WAIT -> FIN with MemError=1 after MOC_TIMEOUT cycles without MemMOC. MemMOV=0; the second word is not issued.
  - RELEASE -> ISSUE (second word) if this was the first word of LDD/STD. The second word uses MemAddress = first address + 4 and, for STD, MemDataIn = StoreData2.
  - RELEASE -> FIN otherwise.
  - FIN: Done=1 for one cycle, Busy=1; next edge returns to IDLE.
- MemMOV is low for at least one full cycle between accesses, so the RAM sees a fresh rising edge.
- Latency with MOC answering immediately, Start accepted at edge N:
  - MemMOV is high for edges N..N+1.
  - Single access: Done high for the cycle after edge N+3.
  - LDD/STD: Done high for the cycle after edge N+6.
- Load results:
  - LD: LoadData = MemDataOut.
  - LDUB/LDUH: zero-extended, as returned by the RAM.
  - LDSB: LoadData = {24{d[7]}, d[7:0]}.
  - LDSH: LoadData = {16{d[15]}, d[15:0]}.
  - LDD: first word -> LoadData, second word -> LoadData2.
- LoadData and LoadData2 hold their values until the next completed load. Stores leave them unchanged.
- Address arithmetic is ADDR_W-bit modulo. Aligned doublewords cannot cross the top of memory (max 504 -> 508).

Test Plan:
- ST 32'hAE910F2B @0, then LD @0 -> Mem[0..3]=AE,91,0F,2B; LoadData=AE910F2B; Done 4 cycles after Start; MemMOV deasserted between accesses.
- STB 8'hF0 @6, then LDSB @6 -> LoadData=FFFFFFF0; LDUB @6 -> 000000F0.
- STD 11223344/55667788 @8, then LDD @8 -> LoadData=11223344, LoadData2=55667788; Done 7 cycles after Start; MemAddress 8 then 12.
- LD @2, LDD @4, LDUH @5, Op3=001111 -> AlignTrap (first three) / IllegalOp (last); each with Done next cycle; MemMOV never asserted.
- MemMOC forced 0 on LD -> MemError+Done after 15 WAIT cycles; MemMOV=0.
- Clr pulsed low during the first word of STD @16 -> immediate IDLE, all outputs 0, address 20 never written; a Start pulse while Busy is ignored.
